fifo_uart_tx: RTL and testbench

Downstream consumer of the byte FIFO. It drains the FIFO one byte at a time and serialises each byte onto a UART line as 8N1: one start bit, 8 data bits LSB first, one stop bit. It sits between the FIFO read port and the board TX pin, and it owns the FIFO read strobe.

---
 rtl/fifo_uart_tx.sv | 135 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO-draining 8N1 UART transmitter. Pops one byte per frame from the FIFO
// read port and shifts it out LSB first. All outputs are registered.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int WIDTH        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             fifo_rd_en,
   output logic             tx,
   output logic             busy,
   output logic             tx_done
);

   // state   | meaning
   // S_IDLE  | line high, sampling fifo_empty each edge
   // S_FETCH | one-cycle FIFO read strobe
   // S_LOAD  | FIFO data valid, captured into shift at closing edge
   // S_START | start bit (tx=0) for CLKS_PER_BIT cycles
   // S_DATA  | WIDTH data bits, LSB first, CLKS_PER_BIT cycles each
   // S_STOP  | stop bit (tx=1); tx_done pulses on the way back to idle
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_STOP
   } state_t;

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
   logic [IDX_W-1:0] bit_idx, bit_idx_n;
   logic [WIDTH-1:0] shift, shift_n;
   logic             tx_n, rd_en_n, busy_n, done_n;
   logic             bit_end;

   assign bit_end = (baud_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         tx         <= 1'b1;
         fifo_rd_en <= 1'b0;
         busy       <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         state      <= state_n;
         baud_cnt   <= baud_cnt_n;
         bit_idx    <= bit_idx_n;
         shift      <= shift_n;
         tx         <= tx_n;
         fifo_rd_en <= rd_en_n;
         busy       <= busy_n;
         tx_done    <= done_n;
      end
   end

   // Next-state and next-output logic; the baud counter falls back to 0
   // whenever it is not explicitly advanced.
   always_comb begin
      state_n    = state;
      baud_cnt_n = '0;
      bit_idx_n  = bit_idx;
      shift_n    = shift;
      tx_n       = tx;
      rd_en_n    = 1'b0;
      busy_n     = busy;
      done_n     = 1'b0;
      case (state)
         S_IDLE: begin
            tx_n   = 1'b1;
            busy_n = 1'b0;
            if (!fifo_empty) begin
               state_n = S_FETCH;
               rd_en_n = 1'b1;
               busy_n  = 1'b1;
            end
         end
         S_FETCH: begin
            state_n = S_LOAD;
            busy_n  = 1'b1;
         end
         S_LOAD: begin
            shift_n = fifo_dout;
            state_n = S_START;
            tx_n    = 1'b0;
         end
         S_START: begin
            if (bit_end) begin
               state_n   = S_DATA;
               bit_idx_n = '0;
               tx_n      = shift[0];
            end else begin
               baud_cnt_n = baud_cnt + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_n = shift >> 1;
               if (bit_idx == IDX_LAST) begin
                  state_n = S_STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_idx_n = bit_idx + IDX_W'(1);
                  tx_n      = shift[1];
               end
            end else begin
               baud_cnt_n = baud_cnt + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               state_n = S_IDLE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               tx_n    = 1'b1;
            end else begin
               baud_cnt_n = baud_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx at CLKS_PER_BIT=4: a queue-backed FIFO model feeds
// the DUT and a line decoder compares every frame against expected bytes.
module tb_fifo_uart_tx;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       fifo_empty;
   logic [7:0] fifo_dout;
   logic       fifo_rd_en, tx, busy, tx_done;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .tx         (tx),
      .busy       (busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rd_cnt = 0;
   int done_cnt = 0;
   logic last_rd = 1'b0;

   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   int         fall_q[$];
   int         done_q[$];

   logic              rx_active = 1'b0;
   int                rx_cnt = 0;
   logic [FRAME-1:0]  rx_line;

   task automatic push_byte(input logic [7:0] b);
      fifo_q.push_back(b);
      exp_q.push_back(b);
      fifo_empty = 1'b0;
   endtask

   // One clock: FIFO model, pulse counters and the line decoder/scoreboard.
   task automatic cycle();
      logic             rd_prev;
      logic [7:0]       exp_b;
      logic [FRAME-1:0] pat;
      int               k;
      rd_prev = fifo_rd_en;
      @(posedge clk);
      #1;
      cyc++;
      if (rd_prev && fifo_q.size() > 0) begin
         fifo_dout  = fifo_q.pop_front();
         fifo_empty = (fifo_q.size() == 0);
      end
      if (fifo_rd_en) begin
         rd_cnt++;
         checks++;
         if (last_rd) begin
            errors++;
            $display("FAIL rd_en_consecutive: cycle %0d saw rd_en high twice in a row, required single pulse", cyc);
         end
      end
      last_rd = fifo_rd_en;
      if (tx_done) begin
         done_cnt++;
         done_q.push_back(cyc);
      end
      if (!rx_active) begin
         if (!tx && !rst) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
            rx_line   = '0;
            rx_line[0] = tx;
            fall_q.push_back(cyc);
         end
      end else begin
         rx_cnt++;
         rx_line[rx_cnt] = tx;
         if (rx_cnt == FRAME - 1) begin
            rx_active = 1'b0;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL frame_unexpected: line 0x%010h with no expected byte queued", rx_line);
            end else begin
               exp_b = exp_q.pop_front();
               for (int i = 0; i < FRAME; i++) begin
                  k = i / CPB;
                  if (k == 0)      pat[i] = 1'b0;
                  else if (k == 9) pat[i] = 1'b1;
                  else             pat[i] = exp_b[k-1];
               end
               if (rx_line !== pat) begin
                  errors++;
                  $display("FAIL frame_bits: line 0x%010h, required 0x%010h (byte 0x%02h)", rx_line, pat, exp_b);
               end
            end
         end
      end
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      for (int i = 0; i < budget && done_cnt < target; i++) cycle();
      checks++;
      if (done_cnt < target) begin
         errors++;
         $display("FAIL %s_timeout: tx_done count %0d, required %0d", name, done_cnt, target);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      fifo_empty = 1'b1;
      fifo_dout = 8'h00;
      repeat (3) cycle();
      checks += 4;
      if (tx !== 1'b1)         begin errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
      if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b, required 0", fifo_rd_en); end
      if (tx_done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b, required 0", tx_done); end
      rst = 1'b0;
      repeat (20) cycle();
      checks += 3;
      if (rd_cnt != 0)   begin errors++; $display("FAIL reset_no_read: rd pulses %0d, required 0", rd_cnt); end
      if (tx !== 1'b1)   begin errors++; $display("FAIL reset_idle_tx: got %b, required 1", tx); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b, required 0", busy); end
   endtask

   task automatic test_single();
      int seen, rd0, d0;
      fall_q.delete();
      done_q.delete();
      rd0 = rd_cnt;
      d0  = done_cnt;
      push_byte(8'hA5);
      seen = cyc;  // cycle in which IDLE sees fifo_empty low
      wait_done(d0 + 1, 80, "single");
      repeat (5) cycle();
      checks += 4;
      if (rd_cnt - rd0 != 1) begin errors++; $display("FAIL single_rd_pulses: got %0d, required 1", rd_cnt - rd0); end
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_pulses: got %0d, required 1", done_cnt - d0); end
      if (fall_q.size() < 1 || fall_q[0] - seen != 3) begin
         errors++;
         $display("FAIL single_fall_latency: got %0d, required 3", (fall_q.size() > 0) ? fall_q[0] - seen : -1);
      end
      if (fall_q.size() < 1 || done_q.size() < 1 || done_q[0] - fall_q[0] != FRAME) begin
         errors++;
         $display("FAIL single_done_latency: got %0d, required %0d",
                  (fall_q.size() > 0 && done_q.size() > 0) ? done_q[0] - fall_q[0] : -1, FRAME);
      end
   endtask

   task automatic test_back_to_back();
      int rd0, d0;
      fall_q.delete();
      done_q.delete();
      rd0 = rd_cnt;
      d0  = done_cnt;
      push_byte(8'h00);
      push_byte(8'hFF);
      wait_done(d0 + 2, 150, "b2b");
      repeat (5) cycle();
      checks += 3;
      if (rd_cnt - rd0 != 2) begin errors++; $display("FAIL b2b_rd_pulses: got %0d, required 2", rd_cnt - rd0); end
      if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_pulses: got %0d, required 2", done_cnt - d0); end
      if (fall_q.size() < 2 || done_q.size() < 1 || fall_q[1] - done_q[0] != 3) begin
         errors++;
         $display("FAIL b2b_gap: got %0d, required 3",
                  (fall_q.size() > 1 && done_q.size() > 0) ? fall_q[1] - done_q[0] : -1);
      end
   endtask

   task automatic test_dout_change();
      int d0;
      d0 = done_cnt;
      push_byte(8'h5A);
      for (int i = 0; i < 60 && !(rx_active && rx_cnt == 12); i++) cycle();
      fifo_dout = 8'h3C;
      wait_done(d0 + 1, 80, "dout_change");
      repeat (3) cycle();
   endtask

   task automatic test_async_reset();
      int d0;
      d0 = done_cnt;
      push_byte(8'h96);
      for (int i = 0; i < 60 && !(rx_active && rx_cnt == 21); i++) cycle();
      checks++;
      if (!(rx_active && rx_cnt == 21)) begin
         errors++;
         $display("FAIL arst_reach_bit4: decoder count %0d, required 21", rx_cnt);
      end
      #2;
      rst = 1'b1;
      #1;
      checks += 2;
      if (tx !== 1'b1)   begin errors++; $display("FAIL arst_tx_immediate: got %b, required 1", tx); end
      if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy_immediate: got %b, required 0", busy); end
      rx_active = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      push_byte(8'hC3);
      repeat (5) cycle();
      checks += 2;
      if (done_cnt != d0) begin errors++; $display("FAIL arst_no_done: tx_done pulses %0d, required 0", done_cnt - d0); end
      if (tx !== 1'b1)    begin errors++; $display("FAIL arst_hold_tx: got %b, required 1", tx); end
      #2;
      rst = 1'b0;
      wait_done(d0 + 1, 80, "arst_refill");
      repeat (3) cycle();
   endtask

   task automatic test_empty_idle();
      int   rd0;
      logic ok;
      rd0 = rd_cnt;
      ok  = 1'b1;
      repeat (200) begin
         cycle();
         if (tx !== 1'b1 || fifo_rd_en !== 1'b0) ok = 1'b0;
      end
      checks += 2;
      if (!ok)           begin errors++; $display("FAIL empty_idle_line: got tx/rd_en disturbance, required tx=1 rd_en=0"); end
      if (rd_cnt != rd0) begin errors++; $display("FAIL empty_idle_reads: got %0d reads, required 0", rd_cnt - rd0); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_dout_change();
      test_async_reset();
      test_empty_idle();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d bytes never seen, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
